// File: rtl/minmax_tracker.sv
// ============================================================================
// minmax_tracker
// Streaming per-frame unsigned min/max tracker with all-equal flag.
// Optional first-occurrence index outputs under macro MINMAX_INDEX_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module minmax_tracker #(
  parameter int WIDTH     = 8,
  parameter int FRAME_LEN = 16,
  parameter int IDX_W     = $clog2(FRAME_LEN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_max,
  output logic [WIDTH-1:0] out_min,
`ifdef MINMAX_INDEX_EN
  output logic [IDX_W-1:0] out_max_idx,
  output logic [IDX_W-1:0] out_min_idx,
`endif
  output logic             out_all_eq
);

  localparam int CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    S_FIRST = 2'd0,
    S_ACCUM = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_max;
  logic [WIDTH-1:0]   r_min;
  logic               r_all_eq;

  logic               w_accept;
  logic               w_gt_max;
  logic               w_lt_min;
  logic               w_ne_max;
  logic               w_last;

  // in_ready is forced low during reset, independent of the state register.
  assign in_ready  = !rst && (r_state != S_HOLD);
  assign w_accept  = in_valid && in_ready;
  assign w_gt_max  = in_data > r_max;
  assign w_lt_min  = in_data < r_min;
  assign w_ne_max  = in_data != r_max;
  assign w_last    = (r_cnt == LAST_CNT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_FIRST;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_FIRST: begin
        if (w_accept) begin
          w_state_nxt = S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (w_accept && w_last) begin
          w_state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          w_state_nxt = S_FIRST;
        end
      end
      default: w_state_nxt = S_FIRST;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_max    <= '0;
      r_min    <= '0;
      r_all_eq <= 1'b0;
    end else begin
      if (w_accept && (r_state == S_FIRST)) begin
        r_cnt    <= CNT_W'(1);
        r_max    <= in_data;
        r_min    <= in_data;
        r_all_eq <= 1'b1;
      end else if (w_accept && (r_state == S_ACCUM)) begin
        r_cnt <= r_cnt + CNT_W'(1);
        // Ties fall through so the first occurrence is kept.
        if (w_gt_max) begin
          r_max <= in_data;
        end
        if (w_lt_min) begin
          r_min <= in_data;
        end
        if (w_ne_max) begin
          r_all_eq <= 1'b0;
        end
      end else if ((r_state == S_HOLD) && out_ready) begin
        r_cnt <= '0;
      end
    end
  end

`ifdef MINMAX_INDEX_EN
  logic [IDX_W-1:0] r_max_idx;
  logic [IDX_W-1:0] r_min_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_max_idx <= '0;
      r_min_idx <= '0;
    end else begin
      if (w_accept && (r_state == S_FIRST)) begin
        r_max_idx <= '0;
        r_min_idx <= '0;
      end else if (w_accept && (r_state == S_ACCUM)) begin
        if (w_gt_max) begin
          r_max_idx <= r_cnt[IDX_W-1:0];
        end
        if (w_lt_min) begin
          r_min_idx <= r_cnt[IDX_W-1:0];
        end
      end
    end
  end

  assign out_max_idx = r_max_idx;
  assign out_min_idx = r_min_idx;
`endif

  assign out_valid  = (r_state == S_HOLD);
  assign out_max    = r_max;
  assign out_min    = r_min;
  assign out_all_eq = r_all_eq;

endmodule

`default_nettype wire

// File: tb/tb_minmax_tracker.sv
// ============================================================================
// tb_minmax_tracker
// Randomized and directed checks of minmax_tracker against a frame-level model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_minmax_tracker;

  localparam int WIDTH     = 8;
  localparam int FRAME_LEN = 4;
  localparam int IDX_W     = $clog2(FRAME_LEN);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] out_max;
  logic [WIDTH-1:0] out_min;
`ifdef MINMAX_INDEX_EN
  logic [IDX_W-1:0] out_max_idx;
  logic [IDX_W-1:0] out_min_idx;
`endif
  logic             out_all_eq;

  int total = 0;
  int bad   = 0;

  int m_max, m_min, m_maxi, m_mini;
  int m_eq;

  minmax_tracker #(
    .WIDTH    (WIDTH),
    .FRAME_LEN(FRAME_LEN)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_max    (out_max),
    .out_min    (out_min),
`ifdef MINMAX_INDEX_EN
    .out_max_idx(out_max_idx),
    .out_min_idx(out_min_idx),
`endif
    .out_all_eq (out_all_eq)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Frame-level reference: extremes first, then first position of each.
  task automatic model(input int s[$]);
    int n_eq;
    m_max = s[0];
    m_min = s[0];
    foreach (s[i]) begin
      if (s[i] > m_max) m_max = s[i];
      if (s[i] < m_min) m_min = s[i];
    end
    m_maxi = -1;
    m_mini = -1;
    n_eq   = 0;
    foreach (s[i]) begin
      if (m_maxi < 0 && s[i] == m_max) m_maxi = i;
      if (m_mini < 0 && s[i] == m_min) m_mini = i;
      if (s[i] == s[0]) n_eq++;
    end
    m_eq = (n_eq == s.size()) ? 1 : 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int s[$], input int gap);
    foreach (s[i]) begin
      if (i > 0 && gap > 0) begin
        in_valid = 1'b0;
        repeat (gap) begin
          tick();
          chk("gap_out_valid", 32'(out_valid), 32'd0);
        end
      end
      in_valid = 1'b1;
      in_data  = WIDTH'(s[i]);
      for (int n = 0; n < 50 && !in_ready; n++) tick();
      chk("in_ready_before_accept", 32'(in_ready), 32'd1);
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic check_result(input string tag);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_in_ready_hold"}, 32'(in_ready), 32'd0);
    chk({tag, "_max"}, 32'(out_max), 32'(m_max));
    chk({tag, "_min"}, 32'(out_min), 32'(m_min));
    chk({tag, "_all_eq"}, 32'(out_all_eq), 32'(m_eq));
`ifdef MINMAX_INDEX_EN
    chk({tag, "_max_idx"}, 32'(out_max_idx), 32'(m_maxi));
    chk({tag, "_min_idx"}, 32'(out_min_idx), 32'(m_mini));
`endif
  endtask

  // Holds the result for `stall` cycles with out_ready low, then releases it.
  task automatic finish_frame(input string tag, input int stall);
    if (stall > 0) begin
      out_ready = 1'b0;
      repeat (stall) begin
        tick();
        chk({tag, "_stall_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_stall_in_ready"}, 32'(in_ready), 32'd0);
        chk({tag, "_stall_max"}, 32'(out_max), 32'(m_max));
        chk({tag, "_stall_min"}, 32'(out_min), 32'(m_min));
      end
      out_ready = 1'b1;
    end
    tick();
    chk({tag, "_release_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_release_in_ready"}, 32'(in_ready), 32'd1);
  endtask

  task automatic run_frame(input string tag, input int s[$], input int gap, input int stall);
    model(s);
    out_ready = 1'b1;
    send_frame(s, gap);
    check_result(tag);
    finish_frame(tag, stall);
  endtask

  initial begin
    int q[$];
    int mode;
    int base;

    #2;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_max", 32'(out_max), 32'd0);
    chk("rst_min", 32'(out_min), 32'd0);
    chk("rst_all_eq", 32'(out_all_eq), 32'd0);
`ifdef MINMAX_INDEX_EN
    chk("rst_max_idx", 32'(out_max_idx), 32'd0);
    chk("rst_min_idx", 32'(out_min_idx), 32'd0);
`endif
    tick();
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    tick();

    q = '{100, 170, 42, 99};
    run_frame("basic", q, 0, 0);
    q = '{5, 200, 200, 5};
    run_frame("ties", q, 0, 0);
    q = '{0, 0, 0, 0};
    run_frame("zeros", q, 0, 0);
    q = '{255, 0, 255, 0};
    run_frame("extremes", q, 0, 0);
    q = '{100, 170, 42, 99};
    run_frame("backpressure", q, 0, 5);
    run_frame("gaps", q, 3, 0);

    // Abort mid-frame with an asynchronous reset.
    in_valid = 1'b1;
    in_data  = 8'd7;
    tick();
    in_data  = 8'd9;
    tick();
    in_valid = 1'b0;
    chk("pre_abort_max", 32'(out_max), 32'd9);
    rst = 1'b1;
    #1;
    chk("abort_max", 32'(out_max), 32'd0);
    chk("abort_min", 32'(out_min), 32'd0);
    chk("abort_all_eq", 32'(out_all_eq), 32'd0);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd0);
`ifdef MINMAX_INDEX_EN
    chk("abort_max_idx", 32'(out_max_idx), 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    tick();
    q = '{1, 2, 3, 4};
    run_frame("after_abort", q, 0, 0);

    for (int f = 0; f < 40; f++) begin
      q    = {};
      mode = int'($urandom_range(0, 2));
      base = int'($urandom_range(0, 255));
      for (int i = 0; i < FRAME_LEN; i++) begin
        case (mode)
          0:       q.push_back(int'($urandom_range(0, 255)));
          1:       q.push_back(int'($urandom_range(0, 2)) * 127);
          default: q.push_back(base);
        endcase
      end
      run_frame("rand", q, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/minmax_tracker.md
# minmax_tracker

Streaming min/max tracker placed directly downstream of the 8-bit magnitude comparator stage. It accepts a frame of FRAME_LEN unsigned samples over a valid/ready handshake. Each new sample is compared (gt/eq/lt, unsigned) against the running maximum and the running minimum. At the end of the frame it presents max, min, their positions and an all-equal flag on an output valid/ready handshake. It is the first block in the lab datapath that holds comparison results across cycles rather than evaluating a single operand pair.

## Interface
- WIDTH, 8, sample width in bits; compare is unsigned.
- FRAME_LEN, 16, samples per frame; legal range 2..256.
- IDX_W, $clog2(FRAME_LEN), derived width of index outputs; not to be overridden.

- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_data holds a sample.
- in_ready  output  1  block can accept a sample this cycle.
- in_data  input  WIDTH  sample.
- out_valid  output  1  frame result is held on the out_* ports.
- out_ready  input  1  consumer accepts the result.
- out_max  output  WIDTH  largest sample of the frame.
- out_min  output  WIDTH  smallest sample of the frame.
- out_max_idx  output  IDX_W  position of the first occurrence of the max (0 = first sample). Present only with MINMAX_INDEX_EN.
- out_min_idx  output  IDX_W  position of the first occurrence of the min. Present only with MINMAX_INDEX_EN.
- out_all_eq  output  1  every sample in the frame equalled the first sample.

## Operation
- A sample is accepted on a rising edge when in_valid && in_ready.
- FSM states: FIRST, ACCUM, HOLD. Reset state is FIRST.
- in_ready = 1 in FIRST and ACCUM, and 0 in HOLD and while rst is high.
- **FIRST:** on accept:
  - max = min = in_data;
  - both indices = 0;
  - all_eq = 1;
  - cnt = 1;
  - go to ACCUM.
- **ACCUM:** on accept, compare in_data against max and min.
  - gt against max: max = in_data, max_idx = cnt.
  - lt against min: min = in_data, min_idx = cnt.
  - Any sample not eq to max: all_eq = 0. Since max = min while all_eq = 1, comparing to max is sufficient.
  - Ties (eq) never update max, min or the indices, so the first occurrence is kept.
  - cnt increments. When the accepted sample has cnt == FRAME_LEN-1, go to HOLD.
- **HOLD:**
  - out_valid = 1 and out_* are stable.
  - On out_valid && out_ready, go to FIRST, clear cnt, and drop out_valid.
- in_valid low in FIRST/ACCUM: state holds, with no partial-frame timeout.
- cnt is IDX_W+1 bits wide and never wraps inside a frame.

## Timing
- Reset values of outputs:
  - out_valid = 0;
  - out_max = 0;
  - out_min = 0;
  - out_max_idx = 0;
  - out_min_idx = 0;
  - out_all_eq = 0;
  - in_ready = 0 while rst is high and 1 on the first cycle after release.
- Latency: out_valid rises on the edge that accepts the last sample, so it is visible one cycle after that sample is presented.
- Throughput:
  - One sample per cycle within a frame.
  - With out_ready held high, HOLD lasts 1 cycle and in_ready is low for exactly 1 cycle between frames.
  - Sustained rate is FRAME_LEN samples per FRAME_LEN+1 cycles.
- out_ready low in HOLD: results are held indefinitely and in_ready stays 0 (backpressure).
- out_ready high outside HOLD: ignored.
- Results are registered outputs, with no combinational path from in_data to out_*.
- rst asserted mid-frame or in HOLD: immediately returns to FIRST, discards the partial frame, and out_valid = 0 without a handshake.

## Configuration
- MINMAX_INDEX_EN defined:
  - Index registers and the out_max_idx / out_min_idx ports exist.
  - Indices update as described above.
- MINMAX_INDEX_EN undefined:
  - Ports and index registers are removed.
  - cnt is still kept for frame termination.
  - All other behaviour and timing are identical.

## Test plan
All scenarios use WIDTH=8, FRAME_LEN=4 and MINMAX_INDEX_EN defined unless noted.
- **Basic frame:** samples 100, 170, 42, 99 back-to-back, out_ready=1 -> one cycle after 99 is accepted: out_max=170, out_min=42, max_idx=1, min_idx=2, all_eq=0.
- **Ties:** samples 5, 200, 200, 5 -> out_max=200, max_idx=1, out_min=5, min_idx=0.
- **All equal and extremes:**
  - Samples 0, 0, 0, 0 -> out_all_eq=1, max=min=0, both indices=0.
  - Samples 255, 0, 255, 0 -> max=255 at index 0, min=0 at index 1.
- **Backpressure:**
  - Hold out_ready=0 for 5 cycles after a frame -> out_valid and results stable, in_ready=0 throughout.
  - Raise out_ready -> out_valid falls next edge and in_ready=1.
  - in_valid gaps of 3 cycles mid-frame -> results identical to the gap-free run.
- **Reset mid-operation:**
  - Assert rst after 2 of 4 samples -> outputs return to reset values asynchronously.
  - A following full frame 1, 2, 3, 4 -> max=4, idx 3, min=1, idx 0.
- **Build without MINMAX_INDEX_EN:** repeat the basic frame -> same max/min/all_eq values and same cycle timing.
